// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage slice.
//   mem_state_t : memory-stage FSM states (idle / waiting for data memory)
//   REG_W       : register-index width
//   DATA_W      : data and address width
package cpu_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
//   dmem_req   : request, held high for the whole transaction
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : transaction address
//   dmem_wdata : store data
//   dmem_rdata : load data, valid while dmem_ack is high
//   dmem_ack   : one-cycle completion pulse
// Modports: master = memory stage, slave = data memory.
interface mem_stage_if;
    import cpu_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : a live instruction completes this cycle
//   en_i       : that instruction writes a register
//   load_i     : capture dest_i/data_i (dest/data hold otherwise)
//   dest_i     : destination register
//   data_i     : write-back value
//   valid_o, en_o, dest_o, data_o : registered MEM/WB contents
// en_o is qualified by valid so a bubble never carries a write enable.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              en_o,
    output logic [REG_W-1:0]  dest_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              en_q;
    logic [REG_W-1:0]  dest_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            en_q    <= valid_i & en_i;
            if (load_i) begin
                dest_q <= dest_i;
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign en_o    = en_q;
    assign dest_o  = dest_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline (between EX and WB).
// Runs a req/ack transaction with data memory for loads and stores, stalls the
// pipe while waiting, aborts after ACK_TIMEOUT cycles without ack (sticky mem_err),
// and registers the write-back result into the MEM/WB register.
// Parameters:
//   ACK_TIMEOUT : max WAIT cycles without dmem_ack before abort (1..255)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   ex_valid, mem_rd, mem_wr, wb_en_in, mem_addr, mem_data, alu_out, reg_dest_in
//                        : instruction from EX (sampled only while idle)
//   flush                : kill the instruction held in this stage
//   dmem                 : data-memory bus (mem_stage_if.master)
//   stall                : high exactly while a transaction is outstanding
//   wb_valid, wb_en, wb_reg_dest, wb_data : MEM/WB register outputs
//   mem_err              : sticky transaction-timeout flag
// Optional feature macro MEM_STAGE_FWD_EN adds fwd_valid/fwd_reg/fwd_data for
// the forwarding unit.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic              flush,
    mem_stage_if.master       dmem,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg_dest,
    output logic [DATA_W-1:0] wb_data,
`ifdef MEM_STAGE_FWD_EN
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              mem_err
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    mem_state_t        state_q;
    logic [7:0]        cnt_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_W-1:0]  dest_q;
    logic              en_q;
    logic              dead_q;   // flushed while waiting: finish the access, drop the result
    logic              err_q;

    logic              accept_alu;
    logic              accept_mem;

    logic              wb_valid_d;
    logic              wb_en_d;
    logic              wb_load_d;
    logic [REG_W-1:0]  wb_dest_d;
    logic [DATA_W-1:0] wb_data_d;

    assign accept_alu = (state_q == MEM_IDLE) && ex_valid && !flush && !(mem_rd || mem_wr);
    assign accept_mem = (state_q == MEM_IDLE) && ex_valid && !flush &&  (mem_rd || mem_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dest_q  <= '0;
            en_q    <= 1'b0;
            dead_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (accept_mem) begin
                        state_q <= MEM_WAIT;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= mem_wr;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_data;
                        dest_q  <= reg_dest_in;
                        en_q    <= wb_en_in;
                        dead_q  <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (flush) begin
                        dead_q <= 1'b1;
                    end
                    if (dmem.dmem_ack) begin
                        state_q <= MEM_IDLE;
                        req_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= MEM_IDLE;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    // Next MEM/WB contents: ALU results retire straight from IDLE, memory
    // results retire on the ack edge unless the instruction was flushed.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_load_d  = 1'b0;
        wb_dest_d  = reg_dest_in;
        wb_data_d  = alu_out;
        if (accept_alu) begin
            wb_valid_d = 1'b1;
            wb_en_d    = wb_en_in;
            wb_load_d  = 1'b1;
        end else if ((state_q == MEM_WAIT) && dmem.dmem_ack && !(dead_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_en_d    = en_q && !we_q;
            wb_load_d  = 1'b1;
            wb_dest_d  = dest_q;
            wb_data_d  = we_q ? '0 : dmem.dmem_rdata;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (wb_valid_d),
        .en_i    (wb_en_d),
        .load_i  (wb_load_d),
        .dest_i  (wb_dest_d),
        .data_i  (wb_data_d),
        .valid_o (wb_valid),
        .en_o    (wb_en),
        .dest_o  (wb_reg_dest),
        .data_o  (wb_data)
    );

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign stall           = (state_q == MEM_WAIT);
    assign mem_err         = err_q;

`ifdef MEM_STAGE_FWD_EN
    assign fwd_valid = wb_valid & wb_en;
    assign fwd_reg   = wb_reg_dest;
    assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, mem_rd, mem_wr, wb_en_in, flush;
    logic [DATA_W-1:0] mem_addr, mem_data, alu_out;
    logic [REG_W-1:0]  reg_dest_in;
    logic              stall, wb_valid, wb_en, mem_err;
    logic [REG_W-1:0]  wb_reg_dest;
    logic [DATA_W-1:0] wb_data;
`ifdef MEM_STAGE_FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_reg;
    logic [DATA_W-1:0] fwd_data;
`endif

    mem_stage_if dif ();

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .wb_en_in    (wb_en_in),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .alu_out     (alu_out),
        .reg_dest_in (reg_dest_in),
        .flush       (flush),
        .dmem        (dif.master),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_en       (wb_en),
        .wb_reg_dest (wb_reg_dest),
        .wb_data     (wb_data),
`ifdef MEM_STAGE_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_data    (fwd_data),
`endif
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_W-1:0]  dest;
        logic              en;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and retire any
    // MEM/WB result against the scoreboard.
    task automatic step();
        wb_t e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_dest", {28'd0, wb_reg_dest}, {28'd0, e.dest});
                chk("wb_en",   {31'd0, wb_en},       {31'd0, e.en});
                chk("wb_data", wb_data,              e.data);
            end
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; wb_en_in = 1'b0;
        flush = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic en,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] alu, input logic [3:0] dest);
        ex_valid = 1'b1; mem_rd = rd; mem_wr = wr; wb_en_in = en;
        mem_addr = addr; mem_data = data; alu_out = alu; reg_dest_in = dest;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        mem_addr = '0; mem_data = '0; alu_out = '0; reg_dest_in = '0;
        dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      {31'd0, dif.dmem_req}, 32'd0);
        chk("rst_stall",    {31'd0, stall},        32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid},     32'd0);
        chk("rst_mem_err",  {31'd0, mem_err},      32'd0);
        chk("rst_wb_data",  wb_data,               32'd0);
        #4 rst_n = 1'b1;

        // ALU op
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1234, 4'd3);
        exp_q.push_back('{dest: 4'd3, en: 1'b1, data: 32'h1234});
        step();
        idle_inputs();
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_stall",    {31'd0, stall},    32'd0);

        // Load, ack during third WAIT cycle
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 4'd5);
        exp_q.push_back('{dest: 4'd5, en: 1'b1, data: 32'hDEADBEEF});
        step();
        idle_inputs();
        mem_addr = 32'h999;
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", {31'd0, stall},        32'd1);
            chk("ld_req",   {31'd0, dif.dmem_req}, 32'd1);
            chk("ld_addr",  dif.dmem_addr,         32'h40);
            chk("ld_we",    {31'd0, dif.dmem_we},  32'd0);
            if (i == 2) begin
                dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
        chk("ld_done_valid", {31'd0, wb_valid},     32'd1);
        chk("ld_done_stall", {31'd0, stall},        32'd0);
        chk("ld_done_req",   {31'd0, dif.dmem_req}, 32'd0);

        // Store
        drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 32'h0, 4'd7);
        exp_q.push_back('{dest: 4'd7, en: 1'b0, data: 32'h0});
        step();
        idle_inputs();
        chk("st_we",    {31'd0, dif.dmem_we},  32'd1);
        chk("st_wdata", dif.dmem_wdata,        32'hA5A5A5A5);
        chk("st_addr",  dif.dmem_addr,         32'h80);
        step();
        dif.dmem_ack = 1'b1;
        step();
        dif.dmem_ack = 1'b0;
        chk("st_done_valid", {31'd0, wb_valid}, 32'd1);
        chk("st_done_en",    {31'd0, wb_en},    32'd0);

        // Flush during WAIT on a store: access completes, result dropped
        drive(1'b0, 1'b1, 1'b1, 32'h84, 32'h11, 32'h0, 4'd2);
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req",   {31'd0, dif.dmem_req}, 32'd1);
        chk("fl_stall", {31'd0, stall},        32'd1);
        chk("fl_addr",  dif.dmem_addr,         32'h84);
        step();
        dif.dmem_ack = 1'b1;
        step();
        dif.dmem_ack = 1'b0;
        chk("fl_wb_valid", {31'd0, wb_valid},     32'd0);
        chk("fl_req_drop", {31'd0, dif.dmem_req}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hBEEF, 4'd9);
        exp_q.push_back('{dest: 4'd9, en: 1'b1, data: 32'hBEEF});
        step();
        idle_inputs();
        chk("fl_next_valid", {31'd0, wb_valid}, 32'd1);

        // Timeout: 4 WAIT cycles then abort
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 4'd4);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            chk("to_req",   {31'd0, dif.dmem_req}, 32'd1);
            chk("to_stall", {31'd0, stall},        32'd1);
            chk("to_err_pending", {31'd0, mem_err}, 32'd0);
            step();
        end
        chk("to_req_drop", {31'd0, dif.dmem_req}, 32'd0);
        chk("to_stall_0",  {31'd0, stall},        32'd0);
        chk("to_mem_err",  {31'd0, mem_err},      32'd1);
        chk("to_wb_valid", {31'd0, wb_valid},     32'd0);
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hBAD;
        step();
        dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
        chk("stray_wb_valid", {31'd0, wb_valid},     32'd0);
        chk("stray_req",      {31'd0, dif.dmem_req}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h55, 4'd1);
        exp_q.push_back('{dest: 4'd1, en: 1'b1, data: 32'h55});
        step();
        idle_inputs();
        chk("err_sticky", {31'd0, mem_err}, 32'd1);

        // Asynchronous reset mid-WAIT
        drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 4'd8);
        step();
        idle_inputs();
        chk("pre_rst_req", {31'd0, dif.dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",      {31'd0, dif.dmem_req}, 32'd0);
        chk("arst_stall",    {31'd0, stall},        32'd0);
        chk("arst_wb_valid", {31'd0, wb_valid},     32'd0);
        chk("arst_mem_err",  {31'd0, mem_err},      32'd0);
        #3 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h777, 4'd6);
        exp_q.push_back('{dest: 4'd6, en: 1'b1, data: 32'h777});
        step();
        idle_inputs();
        chk("post_rst_valid", {31'd0, wb_valid}, 32'd1);
        step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
